// File: rtl/sm_hex_display_scan.sv
// ============================================================================
// Module   : sm_hex_display_scan
// Purpose  : Multiplexed seven-segment scanner with programmable slot length,
//            per-slot blanking dead time, tear-free double-buffered updates and
//            optional 4-bit PWM brightness (enabled by SM_HEX_DISPLAY_PWM_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sm_hex_display_scan #(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 256,
  parameter int BLANK_CYCLES   = 16,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                  clkin,
  input  logic                  reset,
  input  logic [8*DIGITS-1:0]   digits_in,
  input  logic                  load,
  input  logic [3:0]            brightness,
  output logic [7:0]            segments,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  frame_done
);

  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [7:0]        c_seg_dark = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] c_dig_off  = (DIG_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  // Counter and buffer state
  logic [SLOT_W-1:0]     slot_cnt_q, slot_cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [8*DIGITS-1:0]   display_q, display_d;
  logic [8*DIGITS-1:0]   staging_q, staging_d;
  logic                  pending_q, pending_d;

  // Registered outputs
  logic [7:0]            segments_q, segments_d;
  logic [DIGITS-1:0]     digit_en_q, digit_en_d;
  logic                  frame_done_q, frame_done_d;

  logic                  w_slot_last;
  logic                  w_idx_last;
  logic                  w_boundary;
  logic                  w_in_on;
  logic                  w_duty_ok;
  logic [DIGITS-1:0]     w_en_lit;
  logic [7:0]            w_disp [DIGITS];

  // Byte view of the display buffer so the current digit can be selected by idx
  for (genvar k = 0; k < DIGITS; k++) begin : g_unpack
    assign w_disp[k] = display_q[8*k +: 8];
  end

  assign w_slot_last = (slot_cnt_q == SLOT_W'(SCAN_DIV - 1));
  assign w_idx_last  = (idx_q == IDX_W'(DIGITS - 1));
  assign w_boundary  = w_slot_last && w_idx_last;
  assign w_in_on     = (slot_cnt_q >= SLOT_W'(BLANK_CYCLES));

`ifdef SM_HEX_DISPLAY_PWM_EN
  // Only the low nibble of on_cnt matters, and it depends only on the low
  // nibble of slot_cnt, so the subtraction is done at 4 bits.
  logic [3:0] w_on_cnt4;
  assign w_on_cnt4 = slot_cnt_q[3:0] - 4'(BLANK_CYCLES);
  assign w_duty_ok = (w_on_cnt4 <= brightness);
`else
  // Brightness port kept for pin compatibility; digit is lit for the whole ON phase.
  logic w_unused_brightness;
  assign w_unused_brightness = ^brightness;
  assign w_duty_ok           = 1'b1;
`endif

  // Slot/digit counters and double-buffer next state
  always_comb begin
    slot_cnt_d = w_slot_last ? '0 : slot_cnt_q + 1'b1;
    idx_d      = idx_q;
    if (w_slot_last) begin
      idx_d = w_idx_last ? '0 : idx_q + 1'b1;
    end
    display_d = display_q;
    staging_d = staging_q;
    pending_d = pending_q;
    if (w_boundary) begin
      // A load on the boundary wins over older staged data
      if (load) begin
        display_d = digits_in;
        pending_d = 1'b0;
      end else if (pending_q) begin
        display_d = staging_q;
        pending_d = 1'b0;
      end
    end else if (load) begin
      staging_d = digits_in;
      pending_d = 1'b1;
    end
  end

  // Output next state: segments always carry the current digit, enable gated by phase and duty
  always_comb begin
    for (int k = 0; k < DIGITS; k++) begin
      w_en_lit[k] = w_in_on && w_duty_ok && (idx_q == IDX_W'(k));
    end
    segments_d   = (SEG_ACTIVE_LOW != 0) ? ~w_disp[idx_q] : w_disp[idx_q];
    digit_en_d   = (DIG_ACTIVE_LOW != 0) ? ~w_en_lit : w_en_lit;
    frame_done_d = w_boundary;
  end

  // State and output registers with asynchronous reset to the dark state
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      slot_cnt_q   <= '0;
      idx_q        <= '0;
      display_q    <= '0;
      staging_q    <= '0;
      pending_q    <= 1'b0;
      segments_q   <= c_seg_dark;
      digit_en_q   <= c_dig_off;
      frame_done_q <= 1'b0;
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      idx_q        <= idx_d;
      display_q    <= display_d;
      staging_q    <= staging_d;
      pending_q    <= pending_d;
      segments_q   <= segments_d;
      digit_en_q   <= digit_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign segments   = segments_q;
  assign digit_en   = digit_en_q;
  assign frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_sm_hex_display_scan.sv
// ============================================================================
// Module   : tb_sm_hex_display_scan
// Purpose  : Self-checking bench for sm_hex_display_scan (4 digits, 32-cycle
//            slots, 16-cycle blanking) against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sm_hex_display_scan;

  localparam int DIGITS = 4;
  localparam int SCAN   = 32;
  localparam int BLANK  = 16;
  localparam int FRAME  = DIGITS * SCAN;

`ifdef SM_HEX_DISPLAY_PWM_EN
  localparam bit c_pwm = 1'b1;
`else
  localparam bit c_pwm = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] digits_in = '0;
  logic        load = 1'b0;
  logic [3:0]  brightness = 4'hF;
  logic [7:0]  segments;
  logic [3:0]  digit_en;
  logic        frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: cycle count since reset plus the two buffers
  int          m_cyc;
  logic [31:0] m_disp;
  logic [31:0] m_stag;
  bit          m_pend;
  int          last_fd;
  bit          seen_en;
  int          first_en;

  sm_hex_display_scan #(
    .DIGITS(DIGITS), .SCAN_DIV(SCAN), .BLANK_CYCLES(BLANK),
    .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(1)
  ) dut (
    .clkin(clk), .reset(rst), .digits_in(digits_in), .load(load),
    .brightness(brightness), .segments(segments), .digit_en(digit_en),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, m_cyc);
    end
  endtask

  task automatic model_reset();
    m_cyc    = 0;
    m_disp   = '0;
    m_stag   = '0;
    m_pend   = 1'b0;
    last_fd  = -1;
    seen_en  = 1'b0;
    first_en = -1;
  endtask

  // One clock: apply inputs, predict outputs from the model, advance, compare
  task automatic cycle(input logic ld, input logic [31:0] d, input logic [3:0] br);
    int         slot, idx;
    bit         bnd;
    logic [7:0] exp_seg;
    logic [3:0] exp_en;
    load       = ld;
    digits_in  = d;
    brightness = br;
    slot   = m_cyc % SCAN;
    idx    = (m_cyc / SCAN) % DIGITS;
    bnd    = ((m_cyc % FRAME) == FRAME - 1);
    exp_seg = m_disp[idx*8 +: 8];
    exp_en  = 4'hF;
    if (slot >= BLANK && (!c_pwm || ((slot - BLANK) % 16) <= int'(br)))
      exp_en[idx] = 1'b0;
    if (bnd) begin
      if (ld) m_disp = d;
      else if (m_pend) m_disp = m_stag;
      m_pend = 1'b0;
    end else if (ld) begin
      m_stag = d;
      m_pend = 1'b1;
    end
    m_cyc++;
    @(posedge clk);
    #1;
    load = 1'b0;
    check_eq("segments", {24'd0, segments}, {24'd0, exp_seg});
    check_eq("digit_en", {28'd0, digit_en}, {28'd0, exp_en});
    check_eq("frame_done", {31'd0, frame_done}, {31'd0, bnd});
    if (!seen_en && digit_en != 4'hF) begin
      seen_en  = 1'b1;
      first_en = m_cyc;
    end
    if (frame_done) begin
      if (last_fd >= 0) check_eq("fd_gap", m_cyc - last_fd, FRAME);
      last_fd = m_cyc;
    end
  endtask

  task automatic run_idle(input int n, input logic [3:0] br);
    for (int i = 0; i < n; i++) cycle(1'b0, digits_in, br);
  endtask

  // Advance until the next cycle to be driven sits at the given frame position
  task automatic run_to(input int pos, input logic [3:0] br);
    for (int i = 0; i < FRAME && (m_cyc % FRAME) != pos; i++) cycle(1'b0, digits_in, br);
  endtask

  // Asynchronous reset somewhere inside the current clock period
  task automatic async_reset();
    #($urandom_range(2, 4));
    rst = 1'b1;
    #1;
    check_eq("rst_seg", {24'd0, segments}, 32'h00);
    check_eq("rst_en", {28'd0, digit_en}, 32'hF);
    check_eq("rst_fd", {31'd0, frame_done}, 32'h0);
    @(posedge clk);
    #1;
    check_eq("rst_hold_en", {28'd0, digit_en}, 32'hF);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [31:0] a, b;
    model_reset();
    // Power-on reset
    #12;
    check_eq("por_seg", {24'd0, segments}, 32'h00);
    check_eq("por_en", {28'd0, digit_en}, 32'hF);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // First enable after reset: slot 16 state, visible after the 17th edge
    cycle(1'b1, 32'h065B4F66, 4'hF);
    run_idle(20, 4'hF);
    check_eq("first_en", first_en, 17);

    // Basic scan across several frames, full brightness
    run_idle(3 * FRAME, 4'hF);

    // Tear-free update: two loads inside slot 1, only the second shows next frame
    a = $urandom();
    b = $urandom();
    run_to(SCAN + 5, 4'hF);
    cycle(1'b1, a, 4'hF);
    run_idle(7, 4'hF);
    cycle(1'b1, b, 4'hF);
    run_idle(FRAME + 10, 4'hF);

    // Load exactly on the frame boundary cycle
    run_to(FRAME - 1, 4'hF);
    cycle(1'b1, $urandom(), 4'hF);
    run_idle(SCAN + 2, 4'hF);

    // PWM duty at brightness 3 and 0
    run_idle(FRAME, 4'd3);
    run_idle(FRAME, 4'd0);

    // Mid-frame reset followed by first-enable latency again
    run_idle($urandom_range(40, 90), 4'd7);
    async_reset();
    cycle(1'b1, $urandom(), 4'hF);
    run_idle(20, 4'hF);
    check_eq("first_en2", first_en, 17);

    // Randomised loads (including some on the boundary) and brightness changes
    begin
      logic [3:0] br;
      logic       ld;
      br = 4'hF;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 63) == 0) br = 4'($urandom_range(0, 15));
        ld = ($urandom_range(0, 39) == 0);
        if ((m_cyc % FRAME) == FRAME - 1 && $urandom_range(0, 2) == 0) ld = 1'b1;
        cycle(ld, $urandom(), br);
        if (i == 1500) async_reset();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
